// File: rtl/seed_lfsr.sv
// ---------------------------------------------------------------------------
// seed_lfsr
//
// Seed generator for a downstream pseudo-random engine. It delivers a 64-bit
// seed either from a stored preset (mode=0) or from a Fibonacci LFSR that
// advances STEPS times for each request (mode=1). The result is held on
// seed_out with valid=1 until the consumer acknowledges it.
//
// Parameters
//   STEPS         LFSR advances per random request, 1..255
//   DEFAULT_SEED  value stored instead of an all-zero seed
//
// Ports
//   clk        in   single clock, all state changes on its rising edge
//   reset      in   synchronous, active-high reset
//   mode       in   0 = preset seed, 1 = random seed (sampled when leaving IDLE)
//   load       in   one-cycle pulse capturing load_seed into preset and lfsr
//   load_seed  in   64-bit user or preset seed value
//   req        in   request a new seed (honoured only in IDLE)
//   ack        in   consumer has taken seed_out (honoured only in DONE)
//   seed_out   out  delivered seed, stable while valid=1
//   valid      out  seed_out holds a completed seed (state DONE)
//   busy       out  LFSR run in progress (state RUN)
// ---------------------------------------------------------------------------
module seed_lfsr #(
    parameter int unsigned STEPS        = 8,
    parameter logic [63:0] DEFAULT_SEED = 64'hACE1_2468_BDF0_1357
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode,
    input  logic        load,
    input  logic [63:0] load_seed,
    input  logic        req,
    input  logic        ack,
    output logic [63:0] seed_out,
    output logic        valid,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [7:0] STEPS_CNT = 8'(STEPS);

    logic [1:0]  state,  state_nx;
    logic [63:0] preset, preset_nx;
    logic [63:0] lfsr,   lfsr_nx;
    logic [63:0] seed_q, seed_nx;
    logic [7:0]  cnt,    cnt_nx;

    // Value actually stored on a load: an all-zero LFSR would lock up, so
    // zero is replaced by the default seed and can never be stored.
    logic [63:0] load_val;
    assign load_val = (load_seed == 64'd0) ? DEFAULT_SEED : load_seed;

    // One Fibonacci step, taps 64/63/61/60.
    logic        fb;
    logic [63:0] lfsr_step;
    assign fb        = lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59];
    assign lfsr_step = {lfsr[62:0], fb};

    // NOTE: every next-state variable gets a hold default before the case so
    // no path through the block leaves one unassigned, which would infer a latch.
    always_comb begin
        state_nx  = state;
        preset_nx = preset;
        lfsr_nx   = lfsr;
        seed_nx   = seed_q;
        cnt_nx    = cnt;

        case (state)
            IDLE: begin
                // A load wins over a coincident req; the request is dropped.
                if (load) begin
                    preset_nx = load_val;
                    lfsr_nx   = load_val;
                end else if (req) begin
                    if (mode) begin
                        state_nx = RUN;
                        cnt_nx   = STEPS_CNT;
                    end else begin
                        state_nx = DONE;
                        seed_nx  = preset;
                    end
                end
            end

            RUN: begin
                if (load) begin
                    // Abort: reload and return to IDLE without a result.
                    preset_nx = load_val;
                    lfsr_nx   = load_val;
                    cnt_nx    = 8'd0;
                    state_nx  = IDLE;
                end else begin
                    lfsr_nx = lfsr_step;
                    cnt_nx  = cnt - 8'd1;
                    // The last step's result goes straight to seed_out.
                    if (cnt == 8'd1) begin
                        state_nx = DONE;
                        seed_nx  = lfsr_step;
                    end
                end
            end

            DONE: begin
                // The delivered seed is held; a load only refreshes the sources.
                if (load) begin
                    preset_nx = load_val;
                    lfsr_nx   = load_val;
                end
                // req coincident with ack is intentionally not looked at here.
                if (ack) begin
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            preset <= DEFAULT_SEED;
            lfsr   <= DEFAULT_SEED;
            seed_q <= 64'd0;
            cnt    <= 8'd0;
        end else begin
            state  <= state_nx;
            preset <= preset_nx;
            lfsr   <= lfsr_nx;
            seed_q <= seed_nx;
            cnt    <= cnt_nx;
        end
    end

    assign seed_out = seed_q;
    assign valid    = (state == DONE);
    assign busy     = (state == RUN);

endmodule

// File: tb/tb_seed_lfsr.sv
// ---------------------------------------------------------------------------
// tb_seed_lfsr
//
// Self-checking bench for seed_lfsr. Two instances are exercised: one with
// STEPS=8 and one with STEPS=1; they share clk, reset, mode, load and
// load_seed, and each has its own req/ack. A behavioural model per instance
// computes the expected outputs, compared on every falling edge, followed by
// directed scenarios with literal expectations and a randomized phase.
// ---------------------------------------------------------------------------
module tb_seed_lfsr;

    localparam logic [63:0] DEF = 64'hACE1_2468_BDF0_1357;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic        load;
    logic [63:0] load_seed;
    logic        req8, ack8, req1, ack1;
    logic [63:0] seed8, seed1;
    logic        valid8, busy8, valid1, busy1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seed_lfsr #(.STEPS(8), .DEFAULT_SEED(DEF)) dut8 (
        .clk(clk), .reset(reset), .mode(mode), .load(load), .load_seed(load_seed),
        .req(req8), .ack(ack8), .seed_out(seed8), .valid(valid8), .busy(busy8)
    );

    seed_lfsr #(.STEPS(1), .DEFAULT_SEED(DEF)) dut1 (
        .clk(clk), .reset(reset), .mode(mode), .load(load), .load_seed(load_seed),
        .req(req1), .ack(ack1), .seed_out(seed1), .valid(valid1), .busy(busy1)
    );

    // ---------------- behavioural model ----------------
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} phase_t;

    typedef struct {
        phase_t      phase;
        int          remain;   // cycles left until the result appears
        logic [63:0] preset;
        logic [63:0] lfsr;
        logic [63:0] target;   // result of the pending run, known up front
        logic [63:0] out;
    } model_t;

    function automatic logic [63:0] advance(input logic [63:0] x, input int n);
        logic [63:0] v = x;
        for (int i = 0; i < n; i++) v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
        return v;
    endfunction

    function automatic model_t model_next(input model_t m, input logic rst,
                                          input logic ld, input logic [63:0] ls,
                                          input logic rq, input logic md,
                                          input logic ak, input int steps);
        model_t      n = m;
        logic [63:0] v = (ls == 64'd0) ? DEF : ls;
        if (rst) begin
            n.phase = M_IDLE; n.remain = 0;
            n.preset = DEF; n.lfsr = DEF; n.target = DEF; n.out = 64'd0;
            return n;
        end
        case (m.phase)
            M_IDLE: begin
                if (ld) begin
                    n.preset = v; n.lfsr = v;
                end else if (rq && md) begin
                    n.target = advance(m.lfsr, steps);
                    n.remain = steps;
                    n.phase  = M_RUN;
                end else if (rq) begin
                    n.out   = m.preset;
                    n.phase = M_DONE;
                end
            end
            M_RUN: begin
                if (ld) begin
                    n.preset = v; n.lfsr = v; n.phase = M_IDLE;
                end else begin
                    n.remain = m.remain - 1;
                    if (n.remain == 0) begin
                        n.lfsr = m.target; n.out = m.target; n.phase = M_DONE;
                    end
                end
            end
            default: begin
                if (ld) begin
                    n.preset = v; n.lfsr = v;
                end
                if (ak) n.phase = M_IDLE;
            end
        endcase
        return n;
    endfunction

    model_t m8, m1;
    logic   armed = 1'b0;

    always @(posedge clk) begin
        m8 <= model_next(m8, reset, load, load_seed, req8, mode, ack8, 8);
        m1 <= model_next(m1, reset, load, load_seed, req1, mode, ack1, 1);
        if (reset) armed <= 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against their models.
    always @(negedge clk) begin
        if (armed) begin
            check("valid8", {63'd0, valid8}, {63'd0, m8.phase == M_DONE});
            check("busy8",  {63'd0, busy8},  {63'd0, m8.phase == M_RUN});
            check("seed8",  seed8, m8.out);
            check("valid1", {63'd0, valid1}, {63'd0, m1.phase == M_DONE});
            check("busy1",  {63'd0, busy1},  {63'd0, m1.phase == M_RUN});
            check("seed1",  seed1, m1.out);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_load(input logic [63:0] v);
        load = 1'b1; load_seed = v; cyc();
        load = 1'b0; load_seed = 64'd0;
    endtask

    // Pulse req for one cycle, then count cycles until valid (bounded).
    task automatic request(input bit one, input logic md, output int lat, output int busy_n);
        mode = md;
        if (one) req1 = 1'b1; else req8 = 1'b1;
        cyc();
        req1 = 1'b0; req8 = 1'b0;
        lat = 1; busy_n = 0;
        while (!(one ? valid1 : valid8) && lat < 64) begin
            if (one ? busy1 : busy8) busy_n++;
            cyc(); lat++;
        end
    endtask

    task automatic acknowledge(input bit one);
        if (one) ack1 = 1'b1; else ack8 = 1'b1;
        cyc();
        ack1 = 1'b0; ack8 = 1'b0;
    endtask

    int          lat, busy_n;
    logic [63:0] held;

    initial begin
        reset = 1'b1; mode = 1'b0; load = 1'b0; load_seed = 64'd0;
        req8 = 1'b0; ack8 = 1'b0; req1 = 1'b0; ack1 = 1'b0;
        cyc(2);
        reset = 1'b0;
        check("reset_valid", {63'd0, valid8}, 64'd0);
        check("reset_busy",  {63'd0, busy8},  64'd0);
        check("reset_seed",  seed8, 64'd0);

        // Step check: 1 shifted eight times, taps never reached.
        do_load(64'h1);
        request(1'b0, 1'b1, lat, busy_n);
        check("step_latency", 64'(lat), 64'd9);
        check("step_busy_cycles", 64'(busy_n), 64'd8);
        check("step_seed", seed8, 64'h0000_0000_0000_0100);
        check("step_model", m8.out, 64'h0000_0000_0000_0100);
        acknowledge(1'b0);
        check("step_ack_valid", {63'd0, valid8}, 64'd0);

        // Feedback check on the single-step instance.
        do_load(64'h8000_0000_0000_0000);
        request(1'b1, 1'b1, lat, busy_n);
        check("fb_latency", 64'(lat), 64'd2);
        check("fb_seed", seed1, 64'h0000_0000_0000_0001);
        check("fb_model", m1.out, 64'h0000_0000_0000_0001);
        acknowledge(1'b1);

        // Zero-lock check: zero is replaced by the default seed.
        do_load(64'h0);
        request(1'b0, 1'b0, lat, busy_n);
        check("zero_latency", 64'(lat), 64'd1);
        check("zero_seed", seed8, DEF);

        // Handshake check: held while ack=0, req with ack is dropped.
        held = seed8;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("hold_valid", {63'd0, valid8}, 64'd1);
            check("hold_seed", seed8, held);
        end
        ack8 = 1'b1; req8 = 1'b1; cyc();
        ack8 = 1'b0; req8 = 1'b0;
        check("hs_idle_valid", {63'd0, valid8}, 64'd0);
        check("hs_idle_busy",  {63'd0, busy8},  64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("hs_no_second", {63'd0, valid8}, 64'd0);
        end
        request(1'b0, 1'b0, lat, busy_n);
        check("hs_second_latency", 64'(lat), 64'd1);
        check("hs_second_seed", seed8, DEF);
        acknowledge(1'b0);

        // Abort check: load on the 3rd RUN cycle.
        mode = 1'b1; req8 = 1'b1; cyc();
        req8 = 1'b0; cyc(2);
        check("abort_running", {63'd0, busy8}, 64'd1);
        do_load(64'h5);
        check("abort_busy", {63'd0, busy8}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            check("abort_no_valid", {63'd0, valid8}, 64'd0);
            cyc();
        end
        request(1'b0, 1'b1, lat, busy_n);
        check("abort_latency", 64'(lat), 64'd9);
        check("abort_seed", seed8, 64'h0000_0000_0000_0500);
        check("abort_model", m8.out, 64'h0000_0000_0000_0500);
        acknowledge(1'b0);

        // Reset check: reset mid-RUN discards the run.
        mode = 1'b1; req8 = 1'b1; cyc();
        req8 = 1'b0; cyc();
        reset = 1'b1; cyc();
        reset = 1'b0;
        check("rst_valid", {63'd0, valid8}, 64'd0);
        check("rst_busy",  {63'd0, busy8},  64'd0);
        check("rst_seed",  seed8, 64'd0);
        request(1'b0, 1'b0, lat, busy_n);
        check("rst_preset_seed", seed8, DEF);
        acknowledge(1'b0);

        // Randomized phase, checked by the per-cycle compare process.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            load      = ($urandom_range(0, 15) == 0);
            load_seed = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
            mode      = 1'($urandom_range(0, 1));
            req8      = 1'($urandom_range(0, 1));
            ack8      = ($urandom_range(0, 3) == 0);
            req1      = 1'($urandom_range(0, 1));
            ack1      = 1'($urandom_range(0, 1));
            cyc();
        end
        reset = 1'b0; load = 1'b0; req8 = 1'b0; ack8 = 1'b0; req1 = 1'b0; ack1 = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seed_lfsr.md
SEED_LFSR -- requirements
Module: seed_lfsr

Interface
REQ-001 The parameter list SHALL be: STEPS, default 8, number of LFSR advances per random request (1..255).
REQ-002 The parameter list SHALL include: DEFAULT_SEED, default 64'hACE1_2468_BDF0_1357, substitute value for an all-zero seed.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state changes occur on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 Port mode SHALL be an input, 1 bit wide: 0 = preset seed, 1 = random seed; it is driven by the switch-mode controller output.
REQ-006 Port load SHALL be an input, 1 bit wide: a one-cycle pulse that captures load_seed.
REQ-007 Port load_seed SHALL be an input, 64 bits wide: user or preset seed value.
REQ-008 Port req SHALL be an input, 1 bit wide: request for a new seed.
REQ-009 Port ack SHALL be an input, 1 bit wide: the consumer has taken seed_out.
REQ-010 Port seed_out SHALL be an output, 64 bits wide: the delivered seed, stable while valid=1.
REQ-011 Port valid SHALL be an output, 1 bit wide: seed_out holds a completed seed.
REQ-012 Port busy SHALL be an output, 1 bit wide: the block is in RUN.

Function
REQ-013 The block SHALL hold two registers: preset (64b) and lfsr (64b).
REQ-014 One LFSR step SHALL compute lfsr <= {lfsr[62:0], fb}, where fb = lfsr[63]^lfsr[62]^lfsr[60]^lfsr[59].
REQ-015 When load=1, preset and lfsr SHALL take load_seed, or DEFAULT_SEED if load_seed == 0; the all-zero state is never stored.
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-017 In IDLE with req=1 and mode=1, the FSM SHALL go to RUN and set the step counter to STEPS.
REQ-018 In IDLE with req=1 and mode=0, the FSM SHALL go to DONE and set seed_out to preset; lfsr is untouched.
REQ-019 In RUN, each cycle SHALL perform one LFSR step and decrement the counter; when the counter reaches 1, the FSM SHALL go to DONE and seed_out SHALL take the post-step lfsr value.
REQ-020 Latency SHALL be: valid=1 exactly STEPS+1 cycles after req is sampled in mode 1, and 1 cycle after in mode 0.
REQ-021 In DONE, valid SHALL be 1 and seed_out SHALL be held; ack=1 SHALL return the FSM to IDLE with valid=0 on the next cycle.
REQ-022 valid SHALL be 1 only in DONE, and busy SHALL be 1 only in RUN.
REQ-023 req SHALL be ignored in RUN and DONE; a req coincident with ack in DONE SHALL be dropped, and the consumer re-asserts it in IDLE.
REQ-024 ack SHALL be ignored outside DONE.
REQ-025 mode SHALL be sampled only on the IDLE->RUN/DONE transition; a mode change mid-RUN SHALL have no effect.
REQ-026 load in RUN SHALL abort the run: lfsr and preset reload, the FSM goes to IDLE, and no valid is produced.
REQ-027 load in DONE SHALL update preset and lfsr, while seed_out and valid are held until ack.
REQ-028 load in IDLE coincident with req SHALL take priority: the load is applied and req is ignored that cycle.
REQ-029 The step counter SHALL be 8 bits wide, and no arithmetic SHALL exceed 64 bits; the LFSR wraps with its period, with no saturation.

Reset
REQ-030 On reset=1 at a clock edge, the state SHALL become IDLE, valid=0, busy=0, seed_out=0, preset=lfsr=DEFAULT_SEED, and counter=0.
REQ-031 reset SHALL take priority over load, req and ack, including mid-RUN and in DONE; a pending seed is discarded.
REQ-032 Reset SHALL be synchronous only: no output changes without a clk edge.

Verification
REQ-033 The bench SHALL cover the step check: load 64'h1, mode=1, STEPS=8, req -> valid after 9 cycles, seed_out=64'h0000_0000_0000_0100, busy high for 8 cycles.
REQ-034 The bench SHALL cover the feedback check: load 64'h8000_0000_0000_0000, STEPS=1, req -> seed_out=64'h0000_0000_0000_0001.
REQ-035 The bench SHALL cover the zero-lock check: load 64'h0, mode=0, req -> valid after 1 cycle, seed_out=DEFAULT_SEED.
REQ-036 The bench SHALL cover the handshake check: in DONE, hold ack=0 for 5 cycles -> seed_out and valid are stable; ack=1 with req=1 -> IDLE, and a second seed is produced only after req is re-asserted.
REQ-037 The bench SHALL cover the abort check: mode=1, req, load 64'h5 on the 3rd RUN cycle -> IDLE, valid never rises, and a new req yields 64'h5 advanced STEPS steps.
REQ-038 The bench SHALL cover the reset check: reset asserted mid-RUN -> next cycle IDLE, valid=0, busy=0, seed_out=0; a following mode=0 req returns DEFAULT_SEED.
